// File: rtl/proc_run_monitor.sv
// proc_run_monitor: run controller and result checker for the single-cycle
// processor. It parks the processor in reset, releases it for one program run,
// watches the PC for the end address, compares the writeback value with the
// expected result, and bounds each run with a watchdog. It also keeps run/pass
// tallies since the last Reset.
module proc_run_monitor #(
  parameter int DATA_W       = 64,
  parameter int RESET_CYCLES = 2,
  parameter int WDOG_CYCLES  = 255
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic [DATA_W-1:0] start_pc,
  input  logic [DATA_W-1:0] end_pc,
  input  logic [DATA_W-1:0] expected,
  input  logic [DATA_W-1:0] currentpc,
  input  logic [DATA_W-1:0] MemtoRegOut,
  output logic              proc_resetl,
  output logic [DATA_W-1:0] proc_startpc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       cycle_count,
  output logic [7:0]        run_count,
  output logic [7:0]        pass_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Last value of the hold counter before the processor is released.
  localparam logic [15:0] HOLD_LAST = 16'(RESET_CYCLES - 1);
  // cycle_count value at which a run that has not ended is abandoned.
  localparam logic [15:0] WDOG_LIM  = 16'(WDOG_CYCLES);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic [15:0]       r_hold_cnt;
  logic [DATA_W-1:0] r_start_pc;
  logic [DATA_W-1:0] r_end_pc;
  logic [DATA_W-1:0] r_expected;
  logic              r_pass;
  logic              r_timeout;
  logic [15:0]       r_cycle_count;
  logic [7:0]        r_run_count;
  logic [7:0]        r_pass_count;

  logic w_accept;   // start taken this cycle
  logic w_end;      // processor has reached (or passed) the end address
  logic w_wdog;     // watchdog limit reached in this RUN cycle
  logic w_match;    // writeback value equals the expected result

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_end    = (currentpc >= r_end_pc);
  assign w_wdog   = (r_cycle_count == WDOG_LIM);
  assign w_match  = (MemtoRegOut == r_expected);

  // Next-state decode; end and watchdog both leave RUN, their priority is
  // resolved in the result register.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_HOLD;
      S_HOLD:  if (r_hold_cnt == HOLD_LAST) w_next = S_RUN;
      S_RUN:   if (w_end || w_wdog) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register; Reset aborts any run in flight.
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Hold counter: counts HOLD cycles so the processor sees exactly
  // RESET_CYCLES cycles of reset before being released.
  always_ff @(posedge CLK) begin
    if (Reset)                 r_hold_cnt <= '0;
    else if (r_state != S_HOLD) r_hold_cnt <= '0;
    else                       r_hold_cnt <= r_hold_cnt + 16'd1;
  end

  // Capture the run parameters once; later changes on the inputs are ignored
  // until the next accepted start.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_start_pc <= '0;
      r_end_pc   <= '0;
      r_expected <= '0;
    end else if (w_accept) begin
      r_start_pc <= start_pc;
      r_end_pc   <= end_pc;
      r_expected <= expected;
    end
  end

  // Run verdict: a normal end takes priority over a coincident watchdog.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (w_accept) begin
      r_pass    <= 1'b0;
      r_timeout <= 1'b0;
    end else if (r_state == S_RUN) begin
      if (w_end) begin
        r_pass    <= w_match;
        r_timeout <= 1'b0;
      end else if (w_wdog) begin
        r_pass    <= 1'b0;
        r_timeout <= 1'b1;
      end
    end
  end

  // RUN cycle counter: holds the number of RUN cycles including the current
  // one, so it reads 1 in the first RUN cycle and keeps its final value
  // after the run.
  always_ff @(posedge CLK) begin
    if (Reset)
      r_cycle_count <= '0;
    else if (w_accept)
      r_cycle_count <= '0;
    else if (r_state == S_HOLD && w_next == S_RUN)
      r_cycle_count <= 16'd1;
    else if (r_state == S_RUN && w_next == S_RUN && r_cycle_count != 16'hFFFF)
      r_cycle_count <= r_cycle_count + 16'd1;
  end

  // Tallies update as the DONE cycle completes, saturating at 255.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_run_count  <= '0;
      r_pass_count <= '0;
    end else if (r_state == S_DONE) begin
      if (r_run_count != 8'hFF)           r_run_count  <= r_run_count + 8'd1;
      if (r_pass && r_pass_count != 8'hFF) r_pass_count <= r_pass_count + 8'd1;
    end
  end

  assign proc_resetl  = (r_state == S_RUN);
  assign proc_startpc = r_start_pc;
  assign busy         = (r_state == S_HOLD) || (r_state == S_RUN);
  assign done         = (r_state == S_DONE);
  assign pass         = r_pass;
  assign timeout      = r_timeout;
  assign cycle_count  = r_cycle_count;
  assign run_count    = r_run_count;
  assign pass_count   = r_pass_count;

endmodule

// File: tb/tb_proc_run_monitor.sv
// Bench for proc_run_monitor: directed vector table, hand-written watchdog /
// reset sequences, then randomized traffic against a run-level model.
module tb_proc_run_monitor;
  localparam int DW   = 64;
  localparam int RC   = 2;
  localparam int WDOG = 255;
  localparam logic [63:0] X1 = 64'h1234_5678_9abc_def0;

  logic CLK = 1'b0;
  logic rst, st;
  logic [DW-1:0] spc, epc, exv, cpc, mem;
  logic proc_resetl, busy, done, pass, timeout;
  logic [DW-1:0] proc_startpc;
  logic [15:0] cycle_count;
  logic [7:0] run_count, pass_count;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  proc_run_monitor #(.DATA_W(DW), .RESET_CYCLES(RC), .WDOG_CYCLES(WDOG)) dut (
    .CLK(CLK), .Reset(rst), .start(st), .start_pc(spc), .end_pc(epc),
    .expected(exv), .currentpc(cpc), .MemtoRegOut(mem),
    .proc_resetl(proc_resetl), .proc_startpc(proc_startpc), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
    .run_count(run_count), .pass_count(pass_count));

  // Run-level reference: m_t = cycles since the accepted start (0 = no run),
  // RUN time elapsed = m_t - RC.
  int m_t = 0;
  int m_cyc = 0, m_runs = 0, m_passes = 0;
  bit m_done = 0, m_pass = 0, m_to = 0;
  logic [DW-1:0] m_spc = '0, m_end = '0, m_exp = '0;

  task automatic model_step();
    if (rst) begin
      m_t = 0; m_done = 0; m_pass = 0; m_to = 0; m_cyc = 0;
      m_runs = 0; m_passes = 0; m_spc = '0;
    end else if (m_done) begin
      m_done = 0;
      m_runs = (m_runs < 255) ? m_runs + 1 : 255;
      if (m_pass) m_passes = (m_passes < 255) ? m_passes + 1 : 255;
    end else if (m_t == 0) begin
      if (st) begin
        m_spc = spc; m_end = epc; m_exp = exv;
        m_pass = 0; m_to = 0; m_cyc = 0; m_t = 1;
      end
    end else if (m_t <= RC) begin
      m_t++;
      if (m_t > RC) m_cyc = m_t - RC;
    end else begin
      if (cpc >= m_end) begin
        m_pass = (mem == m_exp); m_to = 0; m_t = 0; m_done = 1;
      end else if (m_t - RC == WDOG) begin
        m_pass = 0; m_to = 1; m_t = 0; m_done = 1;
      end else begin
        m_t++;
        m_cyc = (m_t - RC > 65535) ? 65535 : m_t - RC;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  typedef struct {
    logic rst, st;
    logic [63:0] spc, epc, exv, cpc, mem;
    logic e_rl, e_busy, e_done, e_pass, e_to;
    logic [15:0] e_cc;
    logic [7:0] e_rc, e_pc;
    logic [63:0] e_spc;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic [63:0] sp, logic [63:0] ep,
                              logic [63:0] ex, logic [63:0] cp, logic [63:0] mv,
                              logic rl, logic bz, logic dn, logic ps, logic to,
                              logic [15:0] cc, logic [7:0] rcn, logic [7:0] pcn,
                              logic [63:0] so);
    vec_t v;
    v.rst = r; v.st = s; v.spc = sp; v.epc = ep; v.exv = ex; v.cpc = cp; v.mem = mv;
    v.e_rl = rl; v.e_busy = bz; v.e_done = dn; v.e_pass = ps; v.e_to = to;
    v.e_cc = cc; v.e_rc = rcn; v.e_pc = pcn; v.e_spc = so;
    return v;
  endfunction

  task automatic chk_all(input string tag, input logic rl, input logic bz,
                         input logic dn, input logic ps, input logic to,
                         input logic [15:0] cc, input logic [7:0] rcn,
                         input logic [7:0] pcn, input logic [63:0] so);
    chk({tag, ".proc_resetl"}, 64'(proc_resetl), 64'(rl));
    chk({tag, ".busy"},        64'(busy),        64'(bz));
    chk({tag, ".done"},        64'(done),        64'(dn));
    chk({tag, ".pass"},        64'(pass),        64'(ps));
    chk({tag, ".timeout"},     64'(timeout),     64'(to));
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(cc));
    chk({tag, ".run_count"},   64'(run_count),   64'(rcn));
    chk({tag, ".pass_count"},  64'(pass_count),  64'(pcn));
    chk({tag, ".proc_startpc"}, proc_startpc,    so);
  endtask

  vec_t vecs[22];

  initial begin
    int n_hold, n_run;
    bit got;
    rst = 1; st = 0; spc = '0; epc = '0; exv = '0; cpc = '0; mem = '0;

    //             rst st spc     epc     exv  cpc     mem | rl bz dn ps to cc rc pc spc_out
    vecs[0]  = mk(1, 0, 0,      0,      0,   0,      0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0,      0,      0,   0,      0,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0,      'h54,   X1,  0,      0,   0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0,      'h54,   X1,  0,      0,   0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0,      'h54,   X1,  0,      0,   1, 1, 0, 0, 0, 1, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0,      'h54,   X1,  'h10,   0,   1, 1, 0, 0, 0, 2, 0, 0, 0);
    vecs[6]  = mk(0, 0, 0,      'h54,   X1,  'h54,   X1,  0, 0, 1, 1, 0, 2, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0,      'h54,   X1,  0,      0,   0, 0, 0, 1, 0, 2, 1, 1, 0);
    vecs[8]  = mk(0, 0, 0,      'h54,   X1,  0,      0,   0, 0, 0, 1, 0, 2, 1, 1, 0);
    vecs[9]  = mk(0, 1, 0,      'h54,   0,   0,      0,   0, 1, 0, 0, 0, 0, 1, 1, 0);
    vecs[10] = mk(0, 0, 0,      0,      0,   0,      0,   0, 1, 0, 0, 0, 0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0,      0,      0,   0,      0,   1, 1, 0, 0, 0, 1, 1, 1, 0);
    vecs[12] = mk(0, 0, 0,      0,      0,   'h20,   0,   1, 1, 0, 0, 0, 2, 1, 1, 0);
    vecs[13] = mk(0, 0, 0,      0,      0,   'h60,   X1,  0, 0, 1, 0, 0, 2, 1, 1, 0);
    vecs[14] = mk(0, 0, 0,      0,      0,   0,      0,   0, 0, 0, 0, 0, 2, 2, 1, 0);
    vecs[15] = mk(0, 1, 'h100,  'h200,  5,   0,      0,   0, 1, 0, 0, 0, 0, 2, 1, 'h100);
    vecs[16] = mk(0, 1, 'h999,  0,      0,   0,      0,   0, 1, 0, 0, 0, 0, 2, 1, 'h100);
    vecs[17] = mk(0, 1, 'h999,  0,      0,   0,      0,   1, 1, 0, 0, 0, 1, 2, 1, 'h100);
    vecs[18] = mk(0, 1, 'h999,  0,      0,   'h1ff,  5,   1, 1, 0, 0, 0, 2, 2, 1, 'h100);
    vecs[19] = mk(0, 1, 'h999,  0,      0,   'h200,  5,   0, 0, 1, 1, 0, 2, 2, 1, 'h100);
    vecs[20] = mk(0, 1, 'h999,  0,      0,   0,      0,   0, 0, 0, 1, 0, 2, 3, 2, 'h100);
    vecs[21] = mk(0, 0, 'h999,  0,      0,   0,      0,   0, 0, 0, 1, 0, 2, 3, 2, 'h100);

    for (int i = 0; i < 22; i++) begin
      rst = vecs[i].rst; st = vecs[i].st; spc = vecs[i].spc; epc = vecs[i].epc;
      exv = vecs[i].exv; cpc = vecs[i].cpc; mem = vecs[i].mem;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].e_rl, vecs[i].e_busy, vecs[i].e_done,
              vecs[i].e_pass, vecs[i].e_to, vecs[i].e_cc, vecs[i].e_rc,
              vecs[i].e_pc, vecs[i].e_spc);
    end

    // Watchdog: end never reached.
    st = 1; spc = 'h40; epc = 'h1000; exv = 0; cpc = 0; mem = 0;
    tick();
    st = 0;
    n_hold = 0; n_run = 0; got = 0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin got = 1; break; end
      if (busy && !proc_resetl) n_hold++;
      if (busy && proc_resetl) n_run++;
      tick();
    end
    chk("wdog.done_seen", 64'(got), 64'd1);
    chk("wdog.hold_cycles", 64'(n_hold), 64'(RC));
    chk("wdog.run_cycles", 64'(n_run), 64'(WDOG));
    chk_all("wdog", 0, 0, 1, 0, 1, 16'(WDOG), 3, 2, 'h40);
    tick();
    chk_all("wdog_idle", 0, 0, 0, 0, 1, 16'(WDOG), 4, 2, 'h40);

    // End arriving in the watchdog cycle: the normal compare wins.
    st = 1; spc = 'h80; epc = 'h1000; exv = 7;
    tick();
    st = 0; got = 0;
    for (int i = 0; i < 400; i++) begin
      if (busy && cycle_count == 16'(WDOG)) begin got = 1; break; end
      tick();
    end
    chk("tie.reached", 64'(got), 64'd1);
    cpc = 'h1000; mem = 7;
    tick();
    chk_all("tie", 0, 0, 1, 1, 0, 16'(WDOG), 4, 2, 'h80);
    cpc = 0; mem = 0;
    tick();
    chk_all("tie_idle", 0, 0, 0, 1, 0, 16'(WDOG), 5, 3, 'h80);

    // Reset in the middle of a run.
    st = 1; spc = 'hC0; epc = 'h1000;
    tick();
    st = 0;
    repeat (4) tick();
    chk("midrst.running", 64'(proc_resetl), 64'd1);
    rst = 1;
    tick();
    chk_all("midrst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    tick();
    chk_all("midrst_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      st  = ($urandom_range(0, 3) == 0);
      spc = {$urandom, $urandom};
      epc = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                        : 64'($urandom_range(0, 40));
      exv = 64'($urandom_range(0, 3));
      cpc = 64'($urandom_range(0, 45));
      mem = 64'($urandom_range(0, 3));
      tick();
      chk_all("rnd", m_t > RC, m_t > 0, m_done, m_pass, m_to, 16'(m_cyc),
              8'(m_runs), 8'(m_passes), m_spc);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
